// File: rtl/ec_pkg.sv
// Shared encodings for the accumulator-processor control unit: state codes,
// opcodes and accumulator source selects.
package ec_pkg;

    typedef enum logic [3:0] {
        S0  = 4'b0000,
        S1  = 4'b0001,
        S2  = 4'b0010,
        S3  = 4'b1000,
        S4  = 4'b1001,
        S5  = 4'b1010,
        S6  = 4'b1011,
        S7  = 4'b1100,
        S8  = 4'b1101,
        S9  = 4'b1110,
        S10 = 4'b1111
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one register plus an AND gate. RST_VAL=1 suppresses
// an edge for a level already high when reset releases.
module edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) d_q <= RST_VAL;
        else       d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/ec_ctrl_fsm.sv
// Control FSM for the 8-bit accumulator processor: start, fetch, decode and
// one execute state per opcode; INPUT waits for an operator Enter edge.
module ec_ctrl_fsm
    import ec_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic [3:0] state,
    output logic       Halt
);

    state_e state_q, state_d;
    logic   enter_rise;

    // Resets high so a key held through reset is not seen as a press.
    edge_rise #(.RST_VAL(1'b1)) u_enter (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (Enter),
        .rise_o (enter_rise)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:  state_d = S1;
            S1:  state_d = S2;
            S2:  state_d = state_e'({1'b1, IR75});
            S3, S4, S5, S6, S8, S9: state_d = S1;
            S7:  state_d = enter_rise ? S1 : S7;
            S10: state_d = S10;
            default: state_d = S0;
        endcase
    end

    // Moore control word, except the Mealy PCload in S8/S9 and Aload in S7.
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        case (state_q)
            S1: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S2: Meminst = 1'b1;
            S3: begin
                Asel  = ASEL_MEM;
                Aload = 1'b1;
            end
            S4: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S5: Aload = 1'b1;
            S6: begin
                Aload = 1'b1;
                Sub   = 1'b1;
            end
            S7: begin
                Asel  = ASEL_IN;
                Aload = enter_rise;
            end
            S8: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S9: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            default: ;
        endcase
    end

    assign state = state_q;
    assign Halt  = (state_q == S10);

endmodule

// File: tb/tb_ec_ctrl_fsm.sv
// Directed bench for ec_ctrl_fsm: an instruction-phase model checked every
// cycle, plus literal control-word expectations along the way.
module tb_ec_ctrl_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] IR75  = 3'b000;
    logic       Aeq0  = 1'b0;
    logic       Apos  = 1'b0;
    logic       Enter = 1'b0;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] state;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    ec_ctrl_fsm dut (
        .clock(clock), .reset(reset), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
        .Enter(Enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
        .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
        .Sub(Sub), .state(state), .Halt(Halt)
    );

    always #5 clock = ~clock;

    wire [8:0] cw = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub};

    // Model: instruction phase + latched opcode + previous Enter level.
    localparam int PH_START = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3;
    int       m_ph = PH_START;
    logic [2:0] m_op = 3'b000;
    logic     m_enter_prev = 1'b1;

    always @(posedge clock) begin
        m_enter_prev <= reset ? 1'b1 : Enter;
        if (reset) m_ph <= PH_START;
        else begin
            case (m_ph)
                PH_START:  m_ph <= PH_FETCH;
                PH_FETCH:  m_ph <= PH_DECODE;
                PH_DECODE: begin m_ph <= PH_EXEC; m_op <= IR75; end
                default: begin
                    if (m_op == 3'd7) m_ph <= PH_EXEC;
                    else if (m_op == 3'd4) m_ph <= (Enter && !m_enter_prev) ? PH_FETCH : PH_EXEC;
                    else m_ph <= PH_FETCH;
                end
            endcase
        end
    end

    function automatic logic [3:0] exp_state(int ph, logic [2:0] op);
        if (ph == PH_EXEC) return 4'd8 + {1'b0, op};
        return 4'(ph);
    endfunction

    function automatic logic [8:0] exp_cw(int ph, logic [2:0] op, logic z, logic p, logic rise);
        logic irl = 0, jmp = 0, pcl = 0, mi = 0, mw = 0, al = 0, sb = 0;
        logic [1:0] as = 2'd0;
        if (ph == PH_FETCH) begin irl = 1; pcl = 1; end
        else if (ph == PH_DECODE) mi = 1;
        else if (ph == PH_EXEC) begin
            case (op)
                3'd0: begin as = 2'd2; al = 1; end
                3'd1: begin mi = 1; mw = 1; end
                3'd2: al = 1;
                3'd3: begin al = 1; sb = 1; end
                3'd4: begin as = 2'd1; al = rise; end
                3'd5: begin jmp = 1; pcl = z; end
                3'd6: begin jmp = 1; pcl = p; end
                default: ;
            endcase
        end
        return {irl, jmp, pcl, mi, mw, as, al, sb};
    endfunction

    always @(negedge clock) begin
        if (run_cmp) begin
            logic [3:0] es;
            logic [8:0] ec;
            es = exp_state(m_ph, m_op);
            ec = exp_cw(m_ph, m_op, Aeq0, Apos, Enter & ~m_enter_prev);
            n_cmp++;
            if (state !== es || cw !== ec || Halt !== (es == 4'hF)) begin
                n_fail++;
                $display("FAIL model t=%0t state=%b cw=%b halt=%b, expected state=%b cw=%b halt=%b",
                         $time, state, cw, Halt, es, ec, es == 4'hF);
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // From S1: advance to decode, present the opcode, advance into execute.
    task automatic do_instr(input logic [2:0] op);
        tick();
        IR75 = op;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        run_cmp = 1'b1;
        chk("reset_state", 9'(state), 9'h000);
        chk("reset_cw", cw, 9'b000000000);
        chk("reset_halt", 9'(Halt), 9'd0);
        reset = 1'b0;
        tick();
        chk("fetch_state", 9'(state), 9'd1);
        chk("fetch_cw", cw, 9'b101000000);
        tick();
        chk("decode_state", 9'(state), 9'd2);
        chk("decode_cw", cw, 9'b000100000);
        IR75 = 3'b000;
        tick();
        chk("load_state", 9'(state), 9'b000001000);
        chk("load_cw", cw, 9'b000001010);
        tick();
        chk("load_next", 9'(state), 9'd1);

        do_instr(3'b010);
        chk("add_cw", cw, 9'b000000010);
        tick();
        do_instr(3'b011);
        chk("sub_cw", cw, 9'b000000011);
        tick();

        do_instr(3'b101);
        Aeq0 = 1'b1; #1;
        chk("jz_taken", cw, 9'b011000000);
        Aeq0 = 1'b0; #1;
        chk("jz_not", cw, 9'b010000000);
        tick();
        chk("jz_next", 9'(state), 9'd1);
        do_instr(3'b110);
        Apos = 1'b1; #1;
        chk("jpos_taken", cw, 9'b011000000);
        tick();
        chk("jpos_next", 9'(state), 9'd1);
        Apos = 1'b0;
        do_instr(3'b110);
        chk("jpos_not", cw, 9'b010000000);
        tick();

        // INPUT with Enter already held on entry must not fire.
        Enter = 1'b1;
        do_instr(3'b100);
        chk("in_held_cw", cw, 9'b000000100);
        repeat (5) begin
            tick();
            chk("in_wait_state", 9'(state), 9'b000001100);
        end
        Enter = 1'b0;
        tick();
        chk("in_release", 9'(state), 9'b000001100);
        Enter = 1'b1; #1;
        chk("in_press_cw", cw, 9'b000000110);
        tick();
        chk("in_next", 9'(state), 9'd1);
        chk("in_after_aload", 9'(Aload), 9'd0);
        Enter = 1'b0;

        do_instr(3'b111);
        repeat (20) begin
            tick();
            chk("halt_state", 9'(state), 9'b000001111);
            chk("halt_flag", 9'(Halt), 9'd1);
        end
        reset = 1'b1;
        tick();
        chk("halt_reset", 9'(state), 9'd0);
        reset = 1'b0;
        tick();

        do_instr(3'b001);
        chk("store_cw", cw, 9'b000110000);
        reset = 1'b1;
        tick();
        chk("store_reset_state", 9'(state), 9'd0);
        chk("store_reset_memwr", 9'(MemWr), 9'd0);
        reset = 1'b0;
        tick();
        chk("store_no_rewrite", 9'(MemWr), 9'd0);
        tick();
        tick();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
